vga_pixel_fetch: RTL

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: image-memory fetch and test-pattern generator with a 2-cycle, sync-aligned pixel pipeline
module vga_pixel_fetch #(
   parameter int          IMG_W       = 320,
   parameter int          IMG_H       = 240,
   parameter int          ADDR_W      = 17,
   parameter int          BAR_W       = 40,
   parameter logic [11:0] BG_COLOR    = 12'h000,
   parameter logic [11:0] SOLID_COLOR = 12'h00F
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [9:0]        i_x_counter,
   input  logic [9:0]        i_y_counter,
   input  logic              i_video,
   input  logic              i_hsync,
   input  logic              i_vsync,
   input  logic [1:0]        i_mode,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd,
   input  logic [11:0]       i_mem_data,
   output logic [3:0]        o_red,
   output logic [3:0]        o_green,
   output logic [3:0]        o_blue,
   output logic              o_video,
   output logic              o_hsync,
   output logic              o_vsync,
   output logic              o_frame_start
);
   localparam int               PXW     = $clog2(BAR_W + 1);
   localparam logic [10:0]      W_LIM   = 11'(IMG_W);
   localparam logic [10:0]      H_LIM   = 11'(IMG_H);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [PXW-1:0]   PX_LAST = PXW'(BAR_W - 1);
   localparam logic [11:0]      BAR_LUT [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                                12'hF0F, 12'hF00, 12'h00F, 12'h000};
   logic [ADDR_W-1:0] addr_cnt;
   logic [PXW-1:0]    bar_px, px_cur;
   logic [2:0]        bar_idx, idx_cur;
   logic [1:0]        mode_q, mode_now, mode1;
   logic [11:0]       pat, pat1;
   logic              x0, origin, in_image, bar_wrap;
   logic              v1, hs1, vs1, img1, fs1;
   assign o_mem_addr = addr_cnt;
   // Current-pixel decode; the frame origin already uses the newly latched mode
   always_comb begin
      x0       = i_x_counter == '0;
      origin   = x0 && i_y_counter == '0;
      in_image = i_video && {1'b0, i_x_counter} < W_LIM && {1'b0, i_y_counter} < H_LIM;
      mode_now = origin ? i_mode : mode_q;
      px_cur   = x0 ? '0 : bar_px;
      idx_cur  = x0 ? '0 : bar_idx;
      bar_wrap = px_cur == PX_LAST;
      pat      = mode_now == 2'b11 ? SOLID_COLOR :
                 mode_now == 2'b10 ? ((i_x_counter[4] ^ i_y_counter[4]) ? 12'hFFF : 12'h000) :
                 BAR_LUT[idx_cur];
      o_mem_rd = i_rstn && in_image && mode_now == 2'b00;
   end
   // Address, colour-bar and frame-mode counters
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         addr_cnt <= '0;
         bar_px   <= '0;
         bar_idx  <= '0;
         mode_q   <= 2'b00;
      end else begin
         if (!i_vsync) addr_cnt <= '0;
         else if (in_image) addr_cnt <= addr_cnt == LAST ? '0 : addr_cnt + 1'b1;
         bar_px  <= bar_wrap ? '0 : px_cur + 1'b1;
         bar_idx <= (bar_wrap && idx_cur != 3'd7) ? idx_cur + 1'b1 : idx_cur;
         mode_q  <= mode_now;
      end
   end
   // Stage 1: delay timing, mode and pattern alongside the memory read
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         v1    <= 1'b0;
         hs1   <= 1'b1;
         vs1   <= 1'b1;
         img1  <= 1'b0;
         fs1   <= 1'b0;
         mode1 <= 2'b00;
         pat1  <= '0;
      end else begin
         v1    <= i_video;
         hs1   <= i_hsync;
         vs1   <= i_vsync;
         img1  <= in_image;
         fs1   <= origin && i_video;
         mode1 <= mode_now;
         pat1  <= pat;
      end
   end
   // Stage 2: pick the final colour and present it with the aligned syncs
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         {o_red, o_green, o_blue} <= '0;
         o_video       <= 1'b0;
         o_hsync       <= 1'b1;
         o_vsync       <= 1'b1;
         o_frame_start <= 1'b0;
      end else begin
         {o_red, o_green, o_blue} <= !v1 ? 12'h000 : !img1 ? BG_COLOR :
                                     mode1 == 2'b00 ? i_mem_data : pat1;
         o_video       <= v1;
         o_hsync       <= hs1;
         o_vsync       <= vs1;
         o_frame_start <= fs1;
      end
   end
endmodule
